// File: rtl/fetch_cycle.sv
// Instruction fetch stage: one outstanding imem read, 2-entry {pc, inst} FIFO
// toward decode, with branch redirect that discards in-flight responses.
module fetch_cycle #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic [15:0] pcout,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} state_t;

  state_t           state, state_nx;
  logic [15:0]      fetch_pc, fetch_pc_nx;
  logic [1:0][15:0] fifo_pc, fifo_inst;
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count, count_next;
  logic             push, pop;
  logic             req_nx;
  logic [15:0]      addr_nx;

  // A word pushed this cycle is not yet in count, so it cannot pop this cycle.
  always_comb begin
    push       = (state == WAIT) && imem_ack && !branch_taken;
    pop        = (count != 2'd0) && (!valid || !stall) && !branch_taken;
    count_next = count + 2'(push) - 2'(pop);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!branch_taken && count_next < 2'd2) state_nx = WAIT;
      WAIT: begin
        if (branch_taken)                         state_nx = imem_ack ? IDLE : WAIT_DROP;
        else if (imem_ack && count_next == 2'd2)  state_nx = IDLE;
      end
      WAIT_DROP: if (imem_ack) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_nx      = (state_nx != IDLE);
    addr_nx     = imem_addr;
    fetch_pc_nx = fetch_pc;
    if (state == IDLE && state_nx == WAIT) addr_nx = fetch_pc;
    if (push) begin
      fetch_pc_nx = imem_addr + 16'd2;
      if (state_nx == WAIT) addr_nx = imem_addr + 16'd2;
    end
    if (branch_taken) fetch_pc_nx = {branch_target[15:1], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= 16'h0000;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      fifo_pc   <= '0;
      fifo_inst <= '0;
      ir        <= 16'h0000;
      pcout     <= 16'h0000;
      valid     <= 1'b0;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_pc_nx;
      imem_req  <= req_nx;
      imem_addr <= addr_nx;
      if (branch_taken) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        valid  <= 1'b0;
      end else begin
        count <= count_next;
        if (push) begin
          fifo_pc[wr_ptr]   <= imem_addr;
          fifo_inst[wr_ptr] <= imem_rdata;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          ir     <= fifo_inst[rd_ptr];
          pcout  <= fifo_pc[rd_ptr];
          valid  <= 1'b1;
          rd_ptr <= ~rd_ptr;
        end else if (!stall) begin
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle: cycle table for streaming/stall/branch,
// hand sequences for slow-memory branch drop, reset mid-request, PC wrap.
module tb_fetch_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata, ir, pcout;
  logic        valid;
  logic        req2, valid2;
  logic [15:0] addr2, ir2, pcout2;
  logic [3:0]  wcnt, mem_lat;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch_cycle u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .pcout(pcout), .valid(valid)
  );

  fetch_cycle #(.RESET_PC(16'hFFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(16'h0000), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(addr2 ^ 16'hA5A5), .ir(ir2), .pcout(pcout2), .valid(valid2)
  );

  // Memory model: acks on the (mem_lat+1)-th cycle of a request; data = addr ^ A5A5.
  assign imem_ack   = imem_req && (wcnt >= mem_lat);
  assign imem_rdata = imem_ack ? (imem_addr ^ 16'hA5A5) : 16'hDEAD;
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wcnt <= 4'd0;
    else                              wcnt <= wcnt + 4'd1;
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] pc;
    logic [15:0] ir;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic s, logic b, logic [15:0] t, logic rq,
                              logic [15:0] a, logic v, logic [15:0] p, logic [15:0] i);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.req = rq; r.addr = a; r.vld = v; r.pc = p; r.ir = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] wrap_exp [3];
    logic        seen_valid;
    wrap_exp[0] = 16'hFFFC; wrap_exp[1] = 16'hFFFE; wrap_exp[2] = 16'h0000;

    // edge:           stall br tgt      req addr     vld pc       ir
    tbl[0]  = mk(0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0000, 16'hA5A5);
    for (int k = 3; k < 9; k++)
      tbl[k] = mk(1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0000, 16'hA5A5);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0002, 16'hA5A7);
    tbl[10] = mk(0, 0, 16'h0000, 1, 16'h0008, 1, 16'h0004, 16'hA5A1);
    tbl[11] = mk(0, 0, 16'h0000, 1, 16'h000A, 1, 16'h0006, 16'hA5A3);
    tbl[12] = mk(0, 0, 16'h0000, 1, 16'h000C, 1, 16'h0008, 16'hA5AD);
    tbl[13] = mk(1, 1, 16'h0100, 0, 16'h000C, 0, 16'h0000, 16'h0000);
    tbl[14] = mk(1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000);
    tbl[15] = mk(0, 0, 16'h0000, 1, 16'h0102, 0, 16'h0000, 16'h0000);
    tbl[16] = mk(0, 0, 16'h0000, 1, 16'h0104, 1, 16'h0100, 16'hA4A5);

    mem_lat = 4'd0;
    rst = 1'b1;
    tick(); tick();
    chk("reset_state", 64'({imem_req, imem_addr, valid, pcout, ir}), 64'd0);
    chk("reset_state_wrap", 64'({req2, addr2, valid2}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      stall = tbl[i].stall; branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
      tick();
      chk($sformatf("vec%0d", i),
          64'({imem_req, imem_addr, valid, valid ? pcout : 16'h0, valid ? ir : 16'h0}),
          64'({tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc, tbl[i].ir}));
      if (i < 3) chk($sformatf("wrap_addr%0d", i), 64'({req2, addr2}), 64'({1'b1, wrap_exp[i]}));
    end
    stall = 1'b0; branch_taken = 1'b0;

    // Slow memory: branch in first wait cycle, stale response must be dropped.
    rst = 1'b1; mem_lat = 4'd2;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("slow_first_req", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0000}));
    branch_taken = 1'b1; branch_target = 16'h0041;
    tick();
    branch_taken = 1'b0;
    chk("drop_holds_req", 64'({imem_req, imem_addr, valid}), 64'({1'b1, 16'h0000, 1'b0}));
    tick(); tick();
    chk("drop_to_idle", 64'({imem_req, valid}), 64'd0);
    tick();
    chk("redirect_addr", 64'({imem_req, imem_addr, valid}), 64'({1'b1, 16'h0040, 1'b0}));
    seen_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      seen_valid |= valid;
    end
    chk("no_valid_before_data", 64'(seen_valid), 64'd0);
    tick();
    chk("redirect_data", 64'({valid, pcout, ir}), 64'({1'b1, 16'h0040, 16'hA5E5}));

    // Reset while a request is outstanding.
    chk("mid_req_state", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0042}));
    rst = 1'b1;
    tick();
    chk("reset_mid_req", 64'({imem_req, imem_addr, valid, pcout, ir}), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_req", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0000}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
